bch_channel_arbiter: RTL and testbench

//  Shares one 63-bit-frame BCH(63,51) decoder between N_CH serial bit-stream channels.

---
 rtl/bch_channel_arbiter.sv | 169 ++++++++++++++++
 tb/tb_bch_channel_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_channel_arbiter.sv
// rtl/bch_channel_arbiter.sv - round-robin frame arbiter sharing one BCH(63,51) decoder between N_CH bit-serial channels
// Optional: define BCH_ARB_STATS_EN to add the frames_done / frames_per_ch completion counters.
module bch_channel_arbiter #(
  parameter int N_CH      = 4,
  parameter int FRAME_LEN = 63
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   ch_valid,
  input  logic [N_CH-1:0]   ch_data,
  output logic [N_CH-1:0]   ch_ready,
  output logic [N_CH-1:0]   ch_out_valid,
  output logic [N_CH-1:0]   ch_out_data,
  input  logic [N_CH-1:0]   ch_out_ready,
  output logic              dec_in_valid,
  output logic              dec_in_data,
  input  logic              dec_in_ready,
  input  logic              dec_out_valid,
  input  logic              dec_out_data,
  output logic              dec_out_ready,
  output logic [2:0]        grant_ch,
  output logic              busy
`ifdef BCH_ARB_STATS_EN
  ,
  output logic [15:0]       frames_done,
  output logic [N_CH*16-1:0] frames_per_ch
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_UNLOAD = 2'd2
  } state_t;

  localparam logic [5:0] LAST_BEAT = 6'(FRAME_LEN - 1);
  localparam logic [2:0] LAST_CH   = 3'(N_CH - 1);

  state_t     state;
  logic [2:0] rr_ptr;
  logic [5:0] beat_cnt;

  // Channel vectors widened to 8 bits so a 3-bit channel number can index them for any N_CH.
  logic [7:0] valid_pad;
  logic [7:0] data_pad;
  logic [7:0] out_ready_pad;
  assign valid_pad     = 8'(ch_valid);
  assign data_pad      = 8'(ch_data);
  assign out_ready_pad = 8'(ch_out_ready);

  logic g_valid;
  logic g_data;
  logic g_out_ready;
  assign g_valid     = valid_pad[grant_ch];
  assign g_data      = data_pad[grant_ch];
  assign g_out_ready = out_ready_pad[grant_ch];

  logic in_beat;
  logic out_beat;
  assign in_beat  = (state == ST_LOAD) && g_valid && dec_in_ready;
  assign out_beat = (state == ST_UNLOAD) && dec_out_valid && g_out_ready;

  logic       req_any;
  logic [2:0] req_ch;

  // Pick the first requesting channel at or after rr_ptr, wrapping past the last channel.
  always_comb begin
    logic [3:0] idx;
    idx     = '0;
    req_any = 1'b0;
    req_ch  = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = {1'b0, rr_ptr} + 4'(i);
      if (idx >= 4'(N_CH)) idx = idx - 4'(N_CH);
      if (!req_any && valid_pad[idx[2:0]]) begin
        req_any = 1'b1;
        req_ch  = idx[2:0];
      end
    end
  end

  // Route the granted channel's handshakes to the decoder; every other channel sees zeros.
  always_comb begin
    ch_ready     = '0;
    ch_out_valid = '0;
    ch_out_data  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_ch == 3'(i)) begin
        ch_ready[i]     = (state == ST_LOAD) && dec_in_ready;
        ch_out_valid[i] = (state == ST_UNLOAD) && dec_out_valid;
        ch_out_data[i]  = (state == ST_UNLOAD) && dec_out_data;
      end
    end
  end

  assign dec_in_valid  = (state == ST_LOAD) && g_valid;
  assign dec_in_data   = (state == ST_LOAD) && g_data;
  assign dec_out_ready = (state == ST_UNLOAD) && g_out_ready;
  assign busy          = (state != ST_IDLE);

  // Frame sequencer: arbitrate, stream 63 bits into the decoder, stream 63 corrected bits back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      grant_ch <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            grant_ch <= req_ch;
            beat_cnt <= '0;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (in_beat) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= ST_UNLOAD;
            end else begin
              beat_cnt <= beat_cnt + 6'd1;
            end
          end
        end
        ST_UNLOAD: begin
          if (out_beat) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              rr_ptr   <= (grant_ch == LAST_CH) ? 3'd0 : grant_ch + 3'd1;
              state    <= ST_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 6'd1;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

`ifdef BCH_ARB_STATS_EN
  logic        frame_done;
  logic [15:0] per_cnt [N_CH];
  assign frame_done = out_beat && (beat_cnt == LAST_BEAT);

  // Completed-frame counters, total and per channel; all wrap naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_done <= '0;
      for (int i = 0; i < N_CH; i++) per_cnt[i] <= '0;
    end else if (frame_done) begin
      frames_done <= frames_done + 16'd1;
      for (int i = 0; i < N_CH; i++) begin
        if (grant_ch == 3'(i)) per_cnt[i] <= per_cnt[i] + 16'd1;
      end
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_stats
    assign frames_per_ch[gi*16 +: 16] = per_cnt[gi];
  end
`endif

endmodule

// File: tb/tb_bch_channel_arbiter.sv
// tb/tb_bch_channel_arbiter.sv - scoreboard bench for bch_channel_arbiter with a behavioural decoder stub
module tb_bch_channel_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ch_valid, ch_data, ch_ready, ch_out_valid, ch_out_data, ch_out_ready;
  logic        dec_in_valid, dec_in_data, dec_in_ready;
  logic        dec_out_valid, dec_out_data, dec_out_ready;
  logic [2:0]  grant_ch;
  logic        busy;
`ifdef BCH_ARB_STATS_EN
  logic [15:0] frames_done;
  logic [63:0] frames_per_ch;
`endif

  bch_channel_arbiter #(.N_CH(4), .FRAME_LEN(63)) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .ch_out_valid(ch_out_valid), .ch_out_data(ch_out_data), .ch_out_ready(ch_out_ready),
    .dec_in_valid(dec_in_valid), .dec_in_data(dec_in_data), .dec_in_ready(dec_in_ready),
    .dec_out_valid(dec_out_valid), .dec_out_data(dec_out_data), .dec_out_ready(dec_out_ready),
    .grant_ch(grant_ch), .busy(busy)
`ifdef BCH_ARB_STATS_EN
    , .frames_done(frames_done), .frames_per_ch(frames_per_ch)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int ch; bit b; } sb_t;
  sb_t sb_q[$];
  bit  dq_in[$];
  bit  dq_out[$];
  int  grant_log[$];

  bit [62:0] tx_fr [4][4];
  int tx_nfr[4], tx_fi[4], tx_bit[4];
  int corr_pos = -1;
  int stall_ch = -1, stall_rem = 0;
  bit out_rnd = 0, dec_rnd = 0, prev_busy = 0;
  int in_beats, out_beats, dec_out_beats;
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_all();
    for (int c = 0; c < 4; c++) begin tx_nfr[c] = 0; tx_fi[c] = 0; tx_bit[c] = 0; end
    sb_q.delete(); dq_in.delete(); dq_out.delete(); grant_log.delete();
    in_beats = 0; out_beats = 0; dec_out_beats = 0;
  endtask

  task automatic arm(input int c, input bit [62:0] f);
    tx_fr[c][tx_nfr[c]] = f;
    tx_nfr[c]++;
  endtask

  task automatic expect_frame(input int c, input bit [62:0] f);
    sb_t e;
    for (int i = 0; i < 63; i++) begin e.ch = c; e.b = f[i]; sb_q.push_back(e); end
  endtask

  function automatic bit all_sent();
    for (int c = 0; c < 4; c++) if (tx_fi[c] < tx_nfr[c]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: drive at negedge, observe the settled handshakes that the next posedge will consume.
  task automatic cycle();
    bit stalled;
    sb_t e;
    stalled = 0;
    @(negedge clk);
    dec_in_ready  = dec_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    dec_out_valid = (dq_out.size() != 0);
    dec_out_data  = dec_out_valid ? dq_out[0] : 1'b0;
    for (int c = 0; c < 4; c++) begin
      bit v;
      v = (tx_fi[c] < tx_nfr[c]);
      if (v && c == stall_ch && tx_bit[c] == 30 && stall_rem > 0) begin
        v = 0; stall_rem--; stalled = 1;
      end
      ch_valid[c]     = v;
      ch_data[c]      = v ? tx_fr[c][tx_fi[c]][tx_bit[c]] : 1'b0;
      ch_out_ready[c] = out_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    #1;
    if (!busy) chk("idle_quiet", 32'({ch_ready, ch_out_valid, dec_in_valid, dec_out_ready}), 32'd0);
    chk("others_quiet", 32'((ch_ready | ch_out_valid | ch_out_data) & ~(4'b1 << grant_ch)), 32'd0);
    if (stalled) chk("stall_grant_held", 32'({busy, grant_ch}), 32'({1'b1, 3'(stall_ch)}));
    if (busy && !prev_busy) grant_log.push_back(int'(grant_ch));
    prev_busy = busy;
    for (int c = 0; c < 4; c++) begin
      if (ch_valid[c] && ch_ready[c]) begin
        tx_bit[c]++;
        if (tx_bit[c] == 63) begin tx_bit[c] = 0; tx_fi[c]++; end
      end
      if (ch_out_valid[c] && ch_out_ready[c]) begin
        out_beats++;
        if (sb_q.size() == 0) chk("sb_unexpected_out", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          chk("out_ch", 32'(c), 32'(e.ch));
          chk("out_bit", 32'(ch_out_data[c]), 32'(e.b));
        end
      end
    end
    if (dec_in_valid && dec_in_ready) begin
      in_beats++;
      dq_in.push_back(dec_in_data);
      if (dq_in.size() == 63) begin
        for (int i = 0; i < 63; i++) dq_out.push_back(dq_in[i] ^ (i == corr_pos));
        dq_in.delete();
      end
    end
    if (dec_out_valid && dec_out_ready) begin
      dec_out_beats++;
      void'(dq_out.pop_front());
    end
  endtask

  task automatic run_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!(sb_q.size() == 0 && all_sent() && !busy) && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n >= budget), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ch_valid = '0; ch_data = '0; ch_out_ready = '0;
    dec_in_ready = 1'b0; dec_out_valid = 1'b0; dec_out_data = 1'b0;
    clear_all();
    prev_busy = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit [62:0] f, fa[8];
    int exp_order[8];
    int n;

    rst_n = 1'b0;
    ch_valid = '0; ch_data = '0; ch_out_ready = '0;
    dec_in_ready = 1'b0; dec_out_valid = 1'b0; dec_out_data = 1'b0;
    clear_all();
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_ch), 32'd0);
    chk("rst_handshakes", 32'({ch_ready, ch_out_valid, ch_out_data, dec_in_valid, dec_out_ready}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single request on ch1: one-cycle arbitration latency, 63 beats each way.
    f = 63'({$urandom, $urandom});
    arm(1, f); expect_frame(1, f);
    cycle();
    chk("ch1_lat_idle", 32'(busy), 32'd0);
    cycle();
    chk("ch1_lat_grant", 32'({busy, grant_ch}), 32'({1'b1, 3'd1}));
    run_done("ch1", 400);
    chk("ch1_in_beats", 32'(in_beats), 32'd63);
    chk("ch1_out_beats", 32'(out_beats), 32'd63);
    chk("ch1_dec_out_beats", 32'(dec_out_beats), 32'd63);

    // ch2 frame with bit 10 flipped; the decoder stub repairs it, original codeword expected back.
    clear_all();
    f = 63'({$urandom, $urandom});
    corr_pos = 10;
    arm(2, f ^ (63'd1 << 10)); expect_frame(2, f);
    run_done("ch2_err", 400);
    corr_pos = -1;
    chk("ch2_grant", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd2);
    chk("ch2_out_beats", 32'(out_beats), 32'd63);

    // ch3 with a 5-cycle source stall at beat 30 and random back-pressure on both sides.
    clear_all();
    f = 63'({$urandom, $urandom});
    arm(3, f); expect_frame(3, f);
    stall_ch = 3; stall_rem = 5; out_rnd = 1; dec_rnd = 1;
    run_done("ch3_stall", 1500);
    chk("ch3_stall_used", 32'(stall_rem), 32'd0);
    chk("ch3_in_beats", 32'(in_beats), 32'd63);
    chk("ch3_out_beats", 32'(out_beats), 32'd63);
    stall_ch = -1; out_rnd = 0; dec_rnd = 0;

    // Reset at LOAD beat 40 on ch2: everything drops asynchronously, rr_ptr returns to 0.
    clear_all();
    arm(2, 63'({$urandom, $urandom}));
    n = 0;
    while (in_beats < 40 && n < 300) begin cycle(); n++; end
    chk("rst_mid_reach", 32'(in_beats), 32'd40);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_hs", 32'({ch_ready, ch_out_valid, dec_in_valid, dec_out_ready}), 32'd0);
    chk("rst_mid_grant", 32'(grant_ch), 32'd0);
    ch_valid = '0; ch_data = '0;
    dec_out_valid = 1'b0;
    clear_all();
    prev_busy = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // All four channels requesting, two frames each: grants rotate 0,1,2,3,0,1,2,3.
    clear_all();
    for (int k = 0; k < 8; k++) begin
      fa[k] = 63'({$urandom, $urandom});
      exp_order[k] = k % 4;
      arm(k % 4, fa[k]);
      expect_frame(k % 4, fa[k]);
    end
    run_done("rr4", 3000);
    chk("rr4_ngrants", 32'(grant_log.size()), 32'd8);
    for (int k = 0; k < 8; k++)
      chk("rr4_order", 32'(k < grant_log.size() ? grant_log[k] : -1), 32'(exp_order[k]));
    chk("rr4_in_beats", 32'(in_beats), 32'd504);
    chk("rr4_out_beats", 32'(out_beats), 32'd504);

`ifdef BCH_ARB_STATS_EN
    // Three frames on ch0, two on ch2 after a fresh reset.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      int c;
      c = (k % 2 == 0) ? 0 : 2;
      f = 63'({$urandom, $urandom});
      arm(c, f); expect_frame(c, f);
    end
    run_done("stats", 2500);
    chk("stats_total", 32'(frames_done), 32'd5);
    chk("stats_ch0", 32'(frames_per_ch[15:0]), 32'd3);
    chk("stats_ch1", 32'(frames_per_ch[31:16]), 32'd0);
    chk("stats_ch2", 32'(frames_per_ch[47:32]), 32'd2);
    chk("stats_ch3", 32'(frames_per_ch[63:48]), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
